twos_to_sign_bcd: RTL and testbench

Bit-serial decoder that accepts an 8-bit two's-complement value and returns its sign, unsigned magnitude (0–128) and 3-digit BCD magnitude for the seven-segment display path. It sits downstream of the arithmetic datapath, the opposite end from the negation logic. Magnitude recovery reuses a single `full_adder` stepped one bit per clock. BCD conversion is iterative shift-add-3. Both sides use a valid/ready handshake.

---
 rtl/sign_bcd_pkg.sv | 21 ++
 rtl/full_adder.sv | 13 +
 rtl/twos_to_sign_bcd.sv | 137 +++++++++++++
 tb/tb_twos_to_sign_bcd.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sign_bcd_pkg.sv
// rtl/sign_bcd_pkg.sv - shared types and constants for the signed-to-BCD decoder
package sign_bcd_pkg;

  localparam int DATA_W         = 8;
  localparam int BCD_W          = 12;
  localparam int CNT_W          = 3;
  localparam int BCD_ADJ_THRESH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NEG  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Double-dabble correction applied to one digit before each shift.
  function automatic logic [3:0] bcd_adj(input logic [3:0] digit);
    return (digit >= 4'(BCD_ADJ_THRESH)) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder used for serial negation
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/twos_to_sign_bcd.sv
// rtl/twos_to_sign_bcd.sv - bit-serial two's-complement to sign/magnitude/BCD decoder
module twos_to_sign_bcd
  import sign_bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_mag,
  output logic [11:0] out_bcd
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic                carry_q, carry_d;
  logic                out_sign_q, out_sign_d;
  logic [DATA_W-1:0]   out_mag_q, out_mag_d;
  logic [BCD_W-1:0]    out_bcd_q, out_bcd_d;

  logic                fa_a;
  logic                fa_y;
  logic                fa_cout;
  logic [BCD_W-1:0]    acc_adj;

  // XOR with the sign makes the adder transparent for positives, invert+1 for negatives.
  assign fa_a = shift_q[0] ^ sign_q;

  full_adder u_full_adder (
    .A    (fa_a),
    .B    (1'b0),
    .Cin  (carry_q),
    .Y    (fa_y),
    .Cout (fa_cout)
  );

  assign acc_adj = {bcd_adj(acc_q[11:8]), bcd_adj(acc_q[7:4]), bcd_adj(acc_q[3:0])};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    carry_d    = carry_q;
    out_sign_d = out_sign_q;
    out_mag_d  = out_mag_q;
    out_bcd_d  = out_bcd_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          sign_d  = in_data[DATA_W-1];
          carry_d = in_data[DATA_W-1];
          cnt_d   = '0;
          state_d = NEG;
        end
      end
      NEG: begin
        mag_d   = {fa_y, mag_q[DATA_W-1:1]};
        shift_d = shift_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // The emptied shift register becomes the MSB-first feed for the BCD pass.
          shift_d = mag_d;
          carry_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BCD;
        end
      end
      BCD: begin
        acc_d   = {acc_adj[BCD_W-2:0], shift_q[DATA_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          out_sign_d = sign_q;
          out_mag_d  = mag_q;
          out_bcd_d  = acc_d;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      carry_q    <= 1'b0;
      out_sign_q <= 1'b0;
      out_mag_q  <= '0;
      out_bcd_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      carry_q    <= carry_d;
      out_sign_q <= out_sign_d;
      out_mag_q  <= out_mag_d;
      out_bcd_q  <= out_bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_mag   = out_mag_q;
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_twos_to_sign_bcd.sv
// tb/tb_twos_to_sign_bcd.sv - self-checking bench for twos_to_sign_bcd
module tb_twos_to_sign_bcd;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_mag;
  logic [11:0] out_bcd;

  int total;
  int bad;

  twos_to_sign_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_bcd   (out_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mag(input logic [7:0] v);
    int s;
    s = v[7] ? int'(v) - 256 : int'(v);
    if (s < 0) s = -s;
    return 8'(s);
  endfunction

  function automatic logic [11:0] ref_bcd(input int m);
    return 12'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction from the negedge before accept through the output handshake.
  task automatic send(input logic [7:0] v, input int delay, input bit poke);
    logic [7:0]  em;
    logic [11:0] eb;
    int          cyc;
    em  = ref_mag(v);
    eb  = ref_bcd(int'(em));
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~v;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      in_valid = (poke && cyc == 3);
      if (poke) in_data = 8'h55;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'd16);
    check("sign", 32'(out_sign), 32'(v[7]));
    check("mag", 32'(out_mag), 32'(em));
    check("bcd", 32'(out_bcd), 32'(eb));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sign", 32'(out_sign), 32'(v[7]));
      check("hold_mag", 32'(out_mag), 32'(em));
      check("hold_bcd", 32'(out_bcd), 32'(eb));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [7:0]  tp_vals [3];
  int          tp_acc  [3];
  int          idx;
  int          nres;
  int          cyc;

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sign", 32'(out_sign), 32'd0);
    check("rst_mag", 32'(out_mag), 32'd0);
    check("rst_bcd", 32'(out_bcd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h7F, 0, 1'b0);
    check("dir_7f_bcd", 32'(out_bcd), 32'h127);
    send(8'hFF, 0, 1'b0);
    send(8'h80, 0, 1'b0);
    check("dir_80_bcd", 32'(out_bcd), 32'h128);
    send(8'h00, 0, 1'b0);
    send(8'h9C, 10, 1'b1);

    for (int v = 0; v < 256; v++) begin
      send(8'(v), 0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Leave a nonzero held result so the mid-operation reset is observable.
    send(8'h7F, 0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_op_not_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sign", 32'(out_sign), 32'd0);
    check("abort_mag", 32'(out_mag), 32'd0);
    check("abort_bcd", 32'(out_bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hC8, 0, 1'b0);
    check("c8_bcd", 32'(out_bcd), 32'h056);

    tp_vals[0] = 8'h01;
    tp_vals[1] = 8'hFE;
    tp_vals[2] = 8'h64;
    out_ready  = 1'b1;
    idx  = 0;
    nres = 0;
    cyc  = 0;
    while (nres < 3 && cyc < 200) begin
      if (out_valid) begin
        check("tp_sign", 32'(out_sign), 32'(tp_vals[nres][7]));
        check("tp_mag", 32'(out_mag), 32'(ref_mag(tp_vals[nres])));
        check("tp_bcd", 32'(out_bcd), 32'(ref_bcd(int'(ref_mag(tp_vals[nres])))));
        nres++;
      end
      in_valid = (idx < 3);
      if (idx < 3) in_data = tp_vals[idx];
      if (in_ready && idx < 3) begin
        tp_acc[idx] = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("tp_results", 32'(nres), 32'd3);
    check("tp_gap_01", 32'(tp_acc[1] - tp_acc[0]), 32'd18);
    check("tp_gap_12", 32'(tp_acc[2] - tp_acc[1]), 32'd18);
    check("tp_first_bcd_100", 32'(ref_bcd(100)), 32'(out_bcd));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
